// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RV32I encoder turning decoded descriptors into machine words.
// Illegal descriptors emit a nop with out_err set and still take a program address.
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
module instr_encoder (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [31:0]             start_pc,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_op,
    input  logic [2:0]              in_funct3,
    input  logic                    in_alt,
    input  logic [`RFIDX_WIDTH-1:0] in_rd,
    input  logic [`RFIDX_WIDTH-1:0] in_rs1,
    input  logic [`RFIDX_WIDTH-1:0] in_rs2,
    input  logic [31:0]             in_imm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_instr,
    output logic [31:0]             out_pc,
    output logic                    out_err
);
    localparam logic [3:0] OP_LUI = 4'd0, OP_AUIPC = 4'd1, OP_JAL = 4'd2, OP_JALR = 4'd3,
                           OP_BRANCH = 4'd4, OP_LOAD = 4'd5, OP_STORE = 4'd6, OP_IMM = 4'd7,
                           OP_OP = 4'd8;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic                    s1_valid, s1_err;
    logic [3:0]              s1_op;
    logic [2:0]              s1_f3;
    logic [6:0]              s1_f7, f7_c;
    logic [`RFIDX_WIDTH-1:0] s1_rd, s1_rs1, s1_rs2;
    logic [31:0]             s1_imm, pc, word;
    logic                    adv2, err_c, i_ok, b_ok, j_ok, u_ok, shift;
    logic                    unused_pc_bits;
    assign unused_pc_bits = ^start_pc[1:0];
    assign adv2 = !out_valid || out_ready;
    assign in_ready = !start && (!s1_valid || adv2);
    always_comb begin
        i_ok = &in_imm[31:11] || ~|in_imm[31:11];
        b_ok = !in_imm[0] && (&in_imm[31:12] || ~|in_imm[31:12]);
        j_ok = !in_imm[0] && (&in_imm[31:20] || ~|in_imm[31:20]);
        u_ok = ~|in_imm[11:0];
        shift = in_funct3[1:0] == 2'b01;
        case (in_op)
            OP_LUI, OP_AUIPC: err_c = !u_ok;
            OP_JAL:           err_c = !j_ok;
            OP_JALR:          err_c = in_funct3 != 3'd0 || !i_ok;
            OP_BRANCH:        err_c = in_funct3[2:1] == 2'b01 || !b_ok;
            OP_LOAD:          err_c = in_funct3 == 3'b011 || in_funct3[2:1] == 2'b11 || !i_ok;
            OP_STORE:         err_c = in_funct3 > 3'd2 || !i_ok;
            OP_IMM:           err_c = (shift ? |in_imm[31:5] : !i_ok) || (in_alt && in_funct3 != 3'b101);
            OP_OP:            err_c = in_alt && in_funct3 != 3'b000 && in_funct3 != 3'b101;
            default:          err_c = 1'b1;
        endcase
        f7_c = (in_alt && (in_op == OP_OP || (in_op == OP_IMM && in_funct3 == 3'b101))) ? 7'b0100000 : 7'b0000000;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
        end else if (start) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op  <= in_op;
                s1_f3  <= in_funct3;
                s1_f7  <= f7_c;
                s1_rd  <= in_rd;
                s1_rs1 <= in_rs1;
                s1_rs2 <= in_rs2;
                s1_imm <= in_imm;
                s1_err <= err_c;
            end
        end
    end
    always_comb begin
        case (s1_op)
            OP_LUI:    word = {s1_imm[31:12], s1_rd, 7'b0110111};
            OP_AUIPC:  word = {s1_imm[31:12], s1_rd, 7'b0010111};
            OP_JAL:    word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, 7'b1101111};
            OP_JALR:   word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, 7'b1100111};
            OP_BRANCH: word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:1], s1_imm[11], 7'b1100011};
            OP_LOAD:   word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, 7'b0000011};
            OP_STORE:  word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], 7'b0100011};
            OP_IMM:    word = s1_f3[1:0] == 2'b01 ? {s1_f7, s1_imm[4:0], s1_rs1, s1_f3, s1_rd, 7'b0010011}
                                                  : {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, 7'b0010011};
            OP_OP:     word = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, 7'b0110011};
            default:   word = NOP;
        endcase
    end
    // the address is bound when a word enters S2, so flushed S1 entries never consume one
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_pc    <= 32'd0;
            out_err   <= 1'b0;
            pc        <= 32'd0;
        end else if (start) begin
            out_valid <= 1'b0;
            pc        <= {start_pc[31:2], 2'b00};
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= s1_err ? NOP : word;
                out_err   <= s1_err;
                out_pc    <= pc;
                pc        <= pc + 32'd4;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed table, corner sequences and randomized stream against a
// spec-level encoding model with an in-order scoreboard.
module tb_instr_encoder;
    logic        clk = 0, reset = 0, start = 0, in_valid = 0, in_alt = 0, out_ready = 1;
    logic [31:0] start_pc = 0, in_imm = 0;
    logic [3:0]  in_op = 0;
    logic [2:0]  in_funct3 = 0;
    logic [4:0]  in_rd = 0, in_rs1 = 0, in_rs2 = 0;
    logic        in_ready, out_valid, out_err;
    logic [31:0] out_instr, out_pc;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_funct3(in_funct3),
        .in_alt(in_alt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_err(out_err)
    );

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] instr;
        logic        err;
    } vec_t;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mpc = 0;
    int          checks = 0, errors = 0, pops = 0;
    bit          rnd_rdy = 0;
    logic        hold_v = 0, hold_e = 0;
    logic [31:0] hold_i = 0, hold_p = 0;
    logic [31:0] bnd [0:15] = '{32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF, 32'hFFE, 32'hFFF,
                               32'h1000, 32'hFFFFF000, 32'hFFFFEFFE, 32'hFFFFE, 32'h100000,
                               32'hFFF00000, 32'hFFEFFFFE, 32'd31, 32'd32, 32'hFFFFFFFF};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference encoder: legality from signed ranges, fields placed by shift-and-mask arithmetic.
    function automatic logic [32:0] model(input logic [3:0] op, input logic [2:0] f3, input logic alt,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [31:0] imm);
        int          s;
        bit          e, fi, fb, fj, sh;
        logic [31:0] w, rr, ifmt;
        s  = $signed(imm);
        fi = s >= -2048 && s <= 2047;
        fb = (s % 2 == 0) && s >= -4096 && s <= 4094;
        fj = (s % 2 == 0) && s >= -1048576 && s <= 1048574;
        sh = f3 == 3'd1 || f3 == 3'd5;
        rr = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
        ifmt = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
        e = 0;
        w = 0;
        case (op)
            4'd0: begin e = (imm & 32'hFFF) != 0; w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'h37; end
            4'd1: begin e = (imm & 32'hFFF) != 0; w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'h17; end
            4'd2: begin
                e = !fj;
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20)
                  | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'h6F;
            end
            4'd3: begin e = f3 != 0 || !fi; w = ifmt | 32'h67; end
            4'd4: begin
                e = f3 == 3'd2 || f3 == 3'd3 || !fb;
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | rr
                  | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
            end
            4'd5: begin e = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || !fi; w = ifmt | 32'h03; end
            4'd6: begin
                e = f3 > 3'd2 || !fi;
                w = (((imm >> 5) & 32'h7F) << 25) | rr | ((imm & 32'h1F) << 7) | 32'h23;
            end
            4'd7: begin
                if (sh) begin
                    e = imm > 32'd31 || (alt && f3 != 3'd5);
                    w = (alt ? 32'h40000000 : 32'h0) | ((imm & 32'h1F) << 20) | (32'(rs1) << 15)
                      | (32'(f3) << 12) | (32'(rd) << 7) | 32'h13;
                end else begin
                    e = !fi || alt;
                    w = ifmt | 32'h13;
                end
            end
            4'd8: begin
                e = alt && !(f3 inside {3'd0, 3'd5});
                w = (alt ? 32'h40000000 : 32'h0) | rr | (32'(rd) << 7) | 32'h33;
            end
            default: e = 1;
        endcase
        if (e) w = 32'h13;
        return {e, w};
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic [2:0] f3, input logic alt,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic [31:0] instr, input logic err);
        vec_t v;
        v.op = op; v.f3 = f3; v.alt = alt; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.instr = instr; v.err = err;
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t        v;
        logic [32:0] m;
        int          k;
        k = $urandom_range(0, 10);
        v.op  = k == 10 ? 4'($urandom_range(9, 15)) : 4'(k);
        v.f3  = 3'($urandom);
        v.alt = $urandom_range(0, 3) == 0;
        v.rd  = 5'($urandom);
        v.rs1 = 5'($urandom);
        v.rs2 = 5'($urandom);
        case ($urandom_range(0, 4))
            0: v.imm = 32'($urandom_range(0, 64)) - 32'd32;
            1: v.imm = bnd[$urandom_range(0, 15)];
            2: v.imm = $urandom;
            3: v.imm = $urandom & 32'hFFFFF000;
            default: v.imm = ($urandom_range(0, 1) ? 32'hFFF00000 : 32'h0) | ($urandom & 32'h000FFFFE);
        endcase
        m = model(v.op, v.f3, v.alt, v.rd, v.rs1, v.rs2, v.imm);
        v.err = m[32];
        v.instr = m[31:0];
        return v;
    endfunction

    // Output monitor: in-order scoreboard plus stability of a stalled word.
    always @(negedge clk) begin
        if (!reset || start) begin
            hold_v <= 0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_instr", out_instr, hold_i);
                chk("hold_pc", out_pc, hold_p);
                chk("hold_err", 32'(out_err), 32'(hold_e));
            end
            hold_v <= out_valid && !out_ready;
            hold_i <= out_instr;
            hold_p <= out_pc;
            hold_e <= out_err;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got instr %h pc %h, expected no output", out_instr, out_pc);
                end else begin
                    chk("instr", out_instr, sb[0].instr);
                    chk("pc", out_pc, sb[0].pc);
                    chk("err", 32'(out_err), 32'(sb[0].err));
                    void'(sb.pop_front());
                    pops <= pops + 1;
                end
            end
        end
    end

    task automatic drive(input vec_t v);
        in_op = v.op; in_funct3 = v.f3; in_alt = v.alt;
        in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
        in_valid = 1;
    endtask

    task automatic send(input vec_t v);
        int n = 0;
        bit acc = 0;
        drive(v);
        while (!acc && n < 40) begin
            if (rnd_rdy) out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (acc) begin
            sb.push_back('{v.instr, mpc, v.err});
            mpc += 32'd4;
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", n);
        end
    endtask

    task automatic do_start(input logic [31:0] p, input bit try_in);
        start = 1;
        start_pc = p;
        if (try_in) in_valid = 1;
        @(negedge clk);
        chk("start_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        start = 0;
        in_valid = 0;
        sb.delete();
        mpc = p & 32'hFFFFFFFC;
        @(negedge clk);
        chk("start_flush_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 0;
        rnd_rdy = 0;
        out_ready = 1;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[$];
        int   p0;
        tv.push_back(mk(7, 0, 0, 1, 0, 0, 32'd5,        32'h00500093, 0));
        tv.push_back(mk(8, 0, 0, 3, 1, 2, 32'd0,        32'h002081B3, 0));
        tv.push_back(mk(8, 0, 1, 3, 1, 2, 32'd0,        32'h402081B3, 0));
        tv.push_back(mk(6, 2, 0, 0, 1, 2, 32'd8,        32'h0020A423, 0));
        tv.push_back(mk(4, 0, 0, 0, 1, 2, 32'd8,        32'h00208463, 0));
        tv.push_back(mk(2, 0, 0, 1, 0, 0, 32'h800,      32'h001000EF, 0));
        tv.push_back(mk(0, 0, 0, 5, 0, 0, 32'h12345000, 32'h123452B7, 0));
        tv.push_back(mk(7, 0, 0, 1, 0, 0, 32'd2048,     32'h00000013, 1));
        tv.push_back(mk(4, 0, 0, 0, 1, 2, 32'd7,        32'h00000013, 1));
        tv.push_back(mk(12, 0, 0, 1, 2, 3, 32'd0,       32'h00000013, 1));
        tv.push_back(mk(7, 0, 0, 1, 0, 0, 32'hFFFFF800, 32'h80000093, 0));
        tv.push_back(mk(7, 0, 0, 1, 0, 0, 32'd2047,     32'h7FF00093, 0));
        tv.push_back(mk(7, 1, 0, 1, 2, 0, 32'd31,       32'h01F11093, 0));
        tv.push_back(mk(7, 5, 1, 1, 2, 0, 32'd3,        32'h40315093, 0));
        tv.push_back(mk(7, 1, 0, 1, 2, 0, 32'd32,       32'h00000013, 1));
        tv.push_back(mk(4, 0, 0, 0, 0, 0, 32'hFFFFF000, 32'h80000063, 0));
        tv.push_back(mk(4, 0, 0, 0, 0, 0, 32'd4096,     32'h00000013, 1));
        tv.push_back(mk(2, 0, 0, 1, 0, 0, 32'hFFFFFFFE, 32'hFFFFF0EF, 0));
        tv.push_back(mk(2, 0, 0, 1, 0, 0, 32'h100000,   32'h00000013, 1));
        tv.push_back(mk(0, 0, 0, 5, 0, 0, 32'h12345001, 32'h00000013, 1));
        tv.push_back(mk(3, 1, 0, 1, 2, 0, 32'd0,        32'h00000013, 1));
        tv.push_back(mk(5, 3, 0, 1, 2, 0, 32'd0,        32'h00000013, 1));
        tv.push_back(mk(6, 3, 0, 0, 1, 2, 32'd0,        32'h00000013, 1));
        tv.push_back(mk(8, 7, 1, 3, 1, 2, 32'd0,        32'h00000013, 1));
        tv.push_back(mk(7, 0, 1, 1, 0, 0, 32'd5,        32'h00000013, 1));
        tv.push_back(mk(5, 2, 0, 5, 6, 0, 32'hFFFFFFFC, 32'hFFC32283, 0));
        tv.push_back(mk(1, 0, 0, 1, 0, 0, 32'h1000,     32'h00001097, 0));
        tv.push_back(mk(9, 0, 0, 1, 0, 0, 32'd0,        32'h00000013, 1));

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        do_start(32'h100, 0);
        send(tv[0]);
        in_valid = 0;
        @(negedge clk);
        chk("latency_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_cycle2_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        p0 = pops;
        send(tv[1]);
        send(tv[2]);
        send(tv[3]);
        in_valid = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("no_bubble_pops", 32'(pops - p0), 32'd3);
        @(posedge clk);
        #1;
        for (int i = 4; i < tv.size(); i++) send(tv[i]);
        drain();

        do_start(32'hFFFFFFFF, 0);
        out_ready = 0;
        send(tv[0]);
        send(tv[1]);
        drive(tv[2]);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1;
        send(tv[2]);
        drain();

        out_ready = 0;
        send(tv[10]);
        send(tv[11]);
        drive(tv[12]);
        do_start(32'h200, 1);
        out_ready = 1;
        send(tv[4]);
        drain();

        out_ready = 0;
        send(tv[13]);
        send(tv[15]);
        reset = 0;
        in_valid = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_pc", out_pc, 32'd0);
        @(posedge clk);
        #1;
        reset = 1;
        sb.delete();
        mpc = 0;
        out_ready = 1;
        send(tv[5]);
        drain();
        do_start(32'h300, 0);
        send(tv[6]);
        drain();

        do_start($urandom, 0);
        rnd_rdy = 1;
        repeat (400) send(rnd_vec());
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
